// File: rtl/btn_cmd_scheduler_pkg.sv
// Shared types and helpers for the button command scheduler:
// arbiter state encoding and the round-robin pick function.
package btn_cmd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Upper bound on button count supported by rr_pick
    localparam int MAX_BTN = 32;

    // First set bit of pend at or after ptr, wrapping at n_btn; returns ptr when none set
    function automatic int rr_pick(input logic [MAX_BTN-1:0] pend,
                                   input int ptr,
                                   input int n_btn);
        int sel;
        int idx;
        sel = ptr;
        for (int k = MAX_BTN - 1; k >= 0; k--) begin
            if (k < n_btn) begin
                idx = ptr + k;
                if (idx >= n_btn) begin
                    idx = idx - n_btn;
                end else begin
                    idx = idx;
                end
                if (pend[idx]) begin
                    sel = idx;
                end else begin
                    sel = sel;
                end
            end else begin
                sel = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_cmd_scheduler_repeat_timer.sv
// Auto-repeat timer for one button: first tick after REPEAT_DELAY held
// cycles, then one tick every REPEAT_PERIOD cycles until release.
module btn_repeat_timer #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hold,
    output logic o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic [CNT_W-1:0] w_limit;

    assign w_limit = r_phase ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
    assign o_tick  = i_hold & (r_cnt == w_limit);

    // Hold-time counter; release restarts the initial delay phase
    always_ff @(posedge clk) begin
        if (rst || !i_hold) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (o_tick) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_phase <= r_phase;
        end
    end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Merges per-button press pulses and auto-repeat ticks into one
// round-robin arbitrated command stream over a valid/ready handshake.
module btn_cmd_scheduler
    import btn_cmd_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD),
    parameter int ID_W          = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] press_pulse,
    input  logic [N_BTN-1:0] hold_status,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_id,
    output logic             cmd_repeat,
    input  logic             cmd_ready,
    output logic             evt_dropped
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_BTN-1:0]   r_pend;
    logic [N_BTN-1:0]   r_rep;
    logic [N_BTN-1:0]   w_pend_nxt;
    logic [N_BTN-1:0]   w_rep_nxt;
    logic [N_BTN-1:0]   w_tick;
    logic [N_BTN-1:0]   w_drop;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_cmd_id;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_ptr_inc;
    logic [MAX_BTN-1:0] w_pend_ext;
    logic               r_cmd_valid;
    logic               r_cmd_repeat;
    logic               r_evt_dropped;
    logic               w_hs;
    logic               w_grant;

    for (genvar g = 0; g < N_BTN; g++) begin : g_timer
        btn_repeat_timer #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .CNT_W         (CNT_W)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .i_hold (hold_status[g]),
            .o_tick (w_tick[g])
        );
    end

    assign w_hs       = r_cmd_valid & cmd_ready;
    assign w_grant    = (r_state == IDLE) & (|r_pend);
    assign w_pend_ext = MAX_BTN'(r_pend);
    assign w_pick     = ID_W'(rr_pick(w_pend_ext, int'(r_rr_ptr), N_BTN));
    assign w_ptr_inc  = (r_cmd_id == ID_W'(N_BTN - 1)) ? '0 : r_cmd_id + ID_W'(1);

    // Pending/type update: a new event beats a same-cycle handshake clear
    always_comb begin
        w_pend_nxt = r_pend;
        w_rep_nxt  = r_rep;
        w_drop     = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (press_pulse[i] || w_tick[i]) begin
                w_pend_nxt[i] = 1'b1;
                w_rep_nxt[i]  = ~press_pulse[i];
                w_drop[i]     = r_pend[i] & ~(w_hs && (r_cmd_id == ID_W'(i)));
            end else if (w_hs && (r_cmd_id == ID_W'(i))) begin
                w_pend_nxt[i] = 1'b0;
            end else begin
                w_pend_nxt[i] = r_pend[i];
            end
        end
    end

    // Arbiter next-state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = ISSUE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, pending flags and command output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pend        <= '0;
            r_rep         <= '0;
            r_rr_ptr      <= '0;
            r_cmd_id      <= '0;
            r_cmd_repeat  <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_evt_dropped <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend        <= w_pend_nxt;
            r_rep         <= w_rep_nxt;
            r_cmd_valid   <= (w_state_nxt == ISSUE);
            r_evt_dropped <= |w_drop;
            if (w_grant) begin
                r_cmd_id     <= w_pick;
                r_cmd_repeat <= r_rep[w_pick];
                r_rr_ptr     <= r_rr_ptr;
            end else if (w_hs) begin
                r_cmd_id     <= r_cmd_id;
                r_cmd_repeat <= r_cmd_repeat;
                r_rr_ptr     <= w_ptr_inc;
            end else begin
                r_cmd_id     <= r_cmd_id;
                r_cmd_repeat <= r_cmd_repeat;
                r_rr_ptr     <= r_rr_ptr;
            end
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_id      = r_cmd_id;
    assign cmd_repeat  = r_cmd_repeat;
    assign evt_dropped = r_evt_dropped;

endmodule
